// File: rtl/walker_pkg.sv
// Shared definitions for the LED walker demo blocks: motion mode encodings
// and a width helper that never returns zero.
package walker_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROTL   = 2'b01;
    localparam logic [1:0] MODE_ROTR   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Bits needed to index n items; at least 1 so a range of 1 still has a register.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/step_divider.sv
// Clock divider: free-running modulo-CLOCK_DIV counter that only advances
// while enabled, with a single-cycle tick on the last count.
module step_divider
    import walker_pkg::*;
#(
    parameter int CLOCK_DIV = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = clog2w(CLOCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Advance and wrap only while enabled; a disabled cycle keeps the count.
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLOCK_DIV=1 the count is pinned at 0 and this fires every enabled cycle.
    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/led_sweeper.sv
// LED walker: one lit LED that moves across the bank on every divider tick,
// in bounce, rotate-left, rotate-right or hold motion.
module led_sweeper
    import walker_pkg::*;
#(
    parameter int NLEDS     = 8,
    parameter int CLOCK_DIV = 10_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    output logic [NLEDS-1:0]            led,
    output logic [clog2w(NLEDS)-1:0]    pos,
    output logic                        dir,
    output logic                        step
);

    localparam int               PW    = clog2w(NLEDS);
    localparam logic [PW-1:0]    LASTP = PW'(NLEDS - 1);
    localparam logic [NLEDS-1:0] ONE   = NLEDS'(1);

    logic             tick;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [NLEDS-1:0] led_q, led_d;
    logic             step_q, step_d;

    step_divider #(
        .CLOCK_DIV (CLOCK_DIV)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Next position/direction on a tick; led is decoded from the new position
    // so it changes in the same cycle as pos.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = tick;
        if (tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (pos_q == LASTP) begin
                            // Already at the top end while heading up: reverse now.
                            pos_d = pos_q - 1'b1;
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q + 1'b1;
                            dir_d = (pos_d != LASTP);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = PW'(1);
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q - 1'b1;
                            dir_d = (pos_d == '0);
                        end
                    end
                end
                MODE_ROTL: begin
                    pos_d = (pos_q == LASTP) ? '0 : pos_q + 1'b1;
                    dir_d = 1'b1;
                end
                MODE_ROTR: begin
                    pos_d = (pos_q == '0) ? LASTP : pos_q - 1'b1;
                    dir_d = 1'b0;
                end
                default: begin
                    pos_d = pos_q;
                    dir_d = dir_q;
                end
            endcase
            led_d = ONE << pos_d;
        end
    end

    // State registers; reset parks the walker at LED 0 heading up.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q  <= '0;
            dir_q  <= 1'b1;
            led_q  <= ONE;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_sweeper.sv
// Directed bench for led_sweeper: an 8-LED instance with a divide-by-4 step
// rate, plus a 2-LED divide-by-1 instance sharing the same inputs.
module tb_led_sweeper;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;

    logic [7:0] led;
    logic [2:0] pos;
    logic       dir;
    logic       step;

    logic [1:0] led2;
    logic [0:0] pos2;
    logic       dir2;
    logic       step2;

    int         n_cmp  = 0;
    int         n_err  = 0;
    bit         mon_on = 1'b0;
    logic [2:0] cur_pos;

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    always #5 clock = ~clock;

    led_sweeper #(
        .NLEDS     (8),
        .CLOCK_DIV (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .led    (led),
        .pos    (pos),
        .dir    (dir),
        .step   (step)
    );

    led_sweeper #(
        .NLEDS     (2),
        .CLOCK_DIV (1)
    ) dut2 (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .led    (led2),
        .pos    (pos2),
        .dir    (dir2),
        .step   (step2)
    );

    // Invariant monitor: both banks one-hot, led matches pos, pos in range.
    always @(negedge clock) begin
        if (mon_on) begin
            n_cmp++;
            if (!$onehot(led) || (pos > 3'd7) || (led !== (8'd1 << pos))) begin
                n_err++;
                $display("FAIL invariant8 t=%0t: led=%b pos=%0d, want one-hot led == 1<<pos", $time, led, pos);
            end
            n_cmp++;
            if (!$onehot(led2) || (led2 !== (2'd1 << pos2))) begin
                n_err++;
                $display("FAIL invariant2 t=%0t: led=%b pos=%0d, want one-hot led == 1<<pos", $time, led2, pos2);
            end
        end
    end

    // Runs one 4-clock step period from an aligned count: three quiet cycles
    // holding the current position, then the step pulse with the new position.
    task automatic run_step(input logic [2:0] ep, input logic ed, input string nm);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i < 4) begin
                n_cmp++;
                if (step !== 1'b0 || pos !== cur_pos) begin
                    n_err++;
                    $display("FAIL %s quiet cycle %0d: step=%b pos=%0d, want step=0 pos=%0d",
                             nm, i, step, pos, cur_pos);
                end
            end else begin
                n_cmp++;
                if (step !== 1'b1 || pos !== ep || dir !== ed || led !== (8'd1 << ep)) begin
                    n_err++;
                    $display("FAIL %s step: step=%b pos=%0d dir=%b led=%b, want step=1 pos=%0d dir=%b led=%b",
                             nm, step, pos, dir, led, ep, ed, 8'd1 << ep);
                end
            end
        end
        cur_pos = ep;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        cur_pos = 3'd0;
    endtask

    // Expected bounce position/direction after k steps from reset (period 14).
    task automatic bounce_exp(input int k, output logic [2:0] ep, output logic ed);
        int p;
        p  = k % 14;
        ep = 3'((p <= 7) ? p : 14 - p);
        ed = (p < 7);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'b00;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (led !== 8'h01) begin n_err++; $display("FAIL reset_led: got %h want 01", led); end
        n_cmp++;
        if (pos !== 3'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos); end
        n_cmp++;
        if (dir !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b want 1", dir); end
        n_cmp++;
        if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b want 0", step); end
        mon_on  = 1'b1;
        reset   = 1'b0;
        cur_pos = 3'd0;
    endtask

    task automatic test_bounce();
        logic [2:0] ep;
        logic       ed;
        for (int k = 1; k <= 60; k++) begin
            bounce_exp(k, ep, ed);
            run_step(ep, ed, "bounce");
        end
    endtask

    task automatic test_rotate();
        mode = 2'b00;
        apply_reset();
        for (int k = 1; k <= 6; k++) run_step(3'(k), 1'b1, "to_pos6");
        mode = 2'b01;
        run_step(3'd7, 1'b1, "rotl");
        run_step(3'd0, 1'b1, "rotl");
        run_step(3'd1, 1'b1, "rotl");
        mode = 2'b10;
        run_step(3'd0, 1'b0, "rotr");
        run_step(3'd7, 1'b0, "rotr");
        run_step(3'd6, 1'b0, "rotr");
    endtask

    task automatic test_enable_freeze();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_cmp++;
            if (step !== 1'b0 || pos !== 3'd6) begin
                n_err++; $display("FAIL pre_freeze: step=%b pos=%0d, want 0/6", step, pos);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_cmp++;
            if (step !== 1'b0 || pos !== 3'd6 || led !== 8'h40) begin
                n_err++; $display("FAIL frozen: step=%b pos=%0d led=%h, want 0/6/40", step, pos, led);
            end
        end
        enable = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (step !== 1'b0 || pos !== 3'd6) begin
            n_err++; $display("FAIL resume_1: step=%b pos=%0d, want 0/6", step, pos);
        end
        @(negedge clock);
        n_cmp++;
        if (step !== 1'b1 || pos !== 3'd5 || dir !== 1'b0) begin
            n_err++; $display("FAIL resume_2: step=%b pos=%0d dir=%b, want 1/5/0", step, pos, dir);
        end
        cur_pos = 3'd5;
    endtask

    task automatic test_mode_glitch();
        logic [1:0] seq [4];
        seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b00; seq[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            mode = seq[i];
            @(negedge clock);
            n_cmp++;
            if (i < 3) begin
                if (step !== 1'b0 || pos !== 3'd5) begin
                    n_err++; $display("FAIL glitch_quiet %0d: step=%b pos=%0d, want 0/5", i, step, pos);
                end
            end else begin
                if (step !== 1'b1 || pos !== 3'd4 || dir !== 1'b0) begin
                    n_err++; $display("FAIL glitch_step: step=%b pos=%0d dir=%b, want 1/4/0", step, pos, dir);
                end
            end
        end
        cur_pos = 3'd4;
        mode = 2'b11;
        for (int i = 0; i < 3; i++) run_step(3'd4, 1'b0, "hold");
    endtask

    task automatic test_reset_mid();
        logic [2:0] ep;
        logic       ed;
        mode = 2'b00;
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            bounce_exp(k, ep, ed);
            run_step(ep, ed, "to_pos5");
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (led !== 8'h01 || pos !== 3'd0 || dir !== 1'b1 || step !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: led=%h pos=%0d dir=%b step=%b, want 01/0/1/0", led, pos, dir, step);
        end
        reset   = 1'b0;
        cur_pos = 3'd0;
        run_step(3'd1, 1'b1, "after_reset");
        run_step(3'd2, 1'b1, "after_reset");
    endtask

    task automatic test_small();
        logic [0:0] ep;
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'b00;
        @(negedge clock);
        n_cmp++;
        if (led2 !== 2'b01 || pos2 !== 1'b0 || dir2 !== 1'b1 || step2 !== 1'b0) begin
            n_err++;
            $display("FAIL small_reset: led=%b pos=%0d dir=%b step=%b, want 01/0/1/0", led2, pos2, dir2, step2);
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ep = 1'(c % 2);
            @(negedge clock);
            n_cmp++;
            if (pos2 !== ep || dir2 !== (ep == 1'b0) || step2 !== 1'b1 || led2 !== (2'd1 << ep)) begin
                n_err++;
                $display("FAIL small_bounce c=%0d: pos=%0d dir=%b step=%b led=%b, want pos=%0d dir=%b step=1",
                         c, pos2, dir2, step2, led2, ep, ep == 1'b0);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'b00;
        test_reset();
        test_bounce();
        test_rotate();
        test_enable_freeze();
        test_mode_glitch();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
